// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int WORD_W   = 32;
   localparam int STREAK_W = 4;
   localparam int WAIT_W   = 8;

   // Read data handed back when a transaction is abandoned for lack of an ack.
   localparam logic [WORD_W-1:0] ABORT_RDATA = '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of client (instruction refill, data) and shared-memory signals around the arbiter.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic              i_req;
   logic [WORD_W-1:0] i_addr;
   logic [WORD_W-1:0] i_rdata;
   logic              i_ready;

   logic              d_req;
   logic              d_we;
   logic [WORD_W-1:0] d_addr;
   logic [WORD_W-1:0] d_wdata;
   logic [WORD_W-1:0] d_rdata;
   logic              d_ready;

   logic              mem_req;
   logic              mem_we;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              err;

   // The arbiter serves the clients and drives the memory side.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, err
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data wins unless it has already starved a waiting refill.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int D_STREAK = 4
) (
   input  logic                i_req,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_i,
   output logic                grant_d
);

   logic limit_hit;

   assign limit_hit = i_req && (streak == STREAK_W'(D_STREAK));
   assign grant_d   = d_req && !limit_hit;
   assign grant_i   = i_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between instruction refills and data accesses.
// State advances on the falling clock edge to line up with the pipeline registers.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int D_STREAK = 4,
   parameter int TIMEOUT  = 64
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   arb_state_t          state;
   arb_state_t          state_nx;
   logic [STREAK_W-1:0] streak;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                owner_d;
   logic                we_q;
   logic                err_q;
   logic [WORD_W-1:0]   addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [WORD_W-1:0]   i_rdata_q;
   logic [WORD_W-1:0]   d_rdata_q;
   logic [WORD_W-1:0]   done_rdata;

   logic grant_i;
   logic grant_d;
   logic take_i;
   logic take_d;
   logic busy;
   logic ack_hit;
   logic time_up;

   mem_arb_pick #(
      .D_STREAK (D_STREAK)
   ) u_pick (
      .i_req   (bus.i_req),
      .d_req   (bus.d_req),
      .streak  (streak),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   assign busy    = (state == BUSY_I) || (state == BUSY_D);
   assign take_i  = (state == IDLE) && grant_i;
   assign take_d  = (state == IDLE) && grant_d;
   assign ack_hit = busy && bus.mem_ack;
   assign time_up = busy && !bus.mem_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));

   // Writes complete with zero read data rather than whatever the memory drove.
   assign done_rdata = we_q ? '0 : bus.mem_rdata;

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (take_d) begin
               state_nx = BUSY_D;
            end else if (take_i) begin
               state_nx = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (ack_hit || time_up) begin
               state_nx = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request fields are frozen at grant so client changes mid-transaction are ignored.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         streak    <= '0;
         wait_cnt  <= '0;
         owner_d   <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (take_d) begin
         addr_q   <= bus.d_addr;
         wdata_q  <= bus.d_wdata;
         we_q     <= bus.d_we;
         owner_d  <= 1'b1;
         wait_cnt <= '0;
         streak   <= bus.i_req ? streak + 1'b1 : '0;
      end else if (take_i) begin
         addr_q   <= bus.i_addr;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         owner_d  <= 1'b0;
         wait_cnt <= '0;
         streak   <= '0;
      end else if (ack_hit) begin
         if (owner_d) begin
            d_rdata_q <= done_rdata;
         end else begin
            i_rdata_q <= done_rdata;
         end
      end else if (time_up) begin
         err_q <= 1'b1;
         if (owner_d) begin
            d_rdata_q <= ABORT_RDATA;
         end else begin
            i_rdata_q <= ABORT_RDATA;
         end
      end else if (busy) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign bus.mem_req   = busy;
   assign bus.mem_we    = busy && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.i_ready   = (state == RESP) && !owner_d;
   assign bus.d_ready   = (state == RESP) && owner_d;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench-side memory model, grant log and hand-computed expectations.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int          D_STREAK = 4;
   localparam int          TIMEOUT  = 8;
   localparam logic [31:0] I_ADDR   = 32'h0000_1000;
   localparam logic [31:0] D_ADDR   = 32'h0000_2000;

   logic clk;
   logic reset;

   mem_arbiter_if bus ();

   mem_arbiter #(
      .D_STREAK (D_STREAK),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vector_count = 0;
   int miss_count   = 0;

   logic        ack_en;
   int          ack_delay;
   logic [31:0] mem_data;
   int          req_cycles;

   logic [31:0] grant_log[$];
   int          i_pulses;
   int          d_pulses;
   logic        prev_req;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: acks after ack_delay rising edges of a held mem_req.
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      req_cycles    = 0;
      forever begin
         @(posedge clk);
         if (bus.mem_req && ack_en && !bus.mem_ack) begin
            if (req_cycles >= ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_data;
            end else begin
               req_cycles++;
            end
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            if (!bus.mem_req) req_cycles = 0;
         end
      end
   end

   initial begin
      prev_req = 1'b0;
      i_pulses = 0;
      d_pulses = 0;
      forever begin
         @(posedge clk);
         if (bus.mem_req && !prev_req) grant_log.push_back(bus.mem_addr);
         prev_req = bus.mem_req;
         if (bus.i_ready) i_pulses++;
         if (bus.d_ready) d_pulses++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dwd);
      bus.i_req   = ir;
      bus.i_addr  = ia;
      bus.d_req   = dr;
      bus.d_we    = dw;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input bit want_d, input int budget, input string tag, output int cycles);
      cycles = 0;
      forever begin
         tick();
         cycles++;
         if (want_d ? bus.d_ready : bus.i_ready) break;
         if (cycles >= budget) begin
            checkOutput({tag, "_ready_budget"}, 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic wait_grants(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (grant_log.size() < target) begin
         tick();
         n++;
         if (n >= budget) begin
            checkOutput({tag, "_grant_budget"}, 32'(grant_log.size()), 32'(target));
            break;
         end
      end
   endtask

   function automatic logic [31:0] log_at(input int k);
      return (k < grant_log.size()) ? grant_log[k] : 32'hFFFF_FFFF;
   endfunction

   initial begin
      int          cyc;
      int          busy_cycles;
      int          base;
      int          pulses_before;
      logic [31:0] exp_addr;

      reset     = 1'b1;
      ack_en    = 1'b1;
      ack_delay = 0;
      mem_data  = '0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

      repeat (3) tick();
      checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      checkOutput("rst_i_ready", 32'(bus.i_ready), 32'd0);
      checkOutput("rst_d_ready", 32'(bus.d_ready), 32'd0);
      checkOutput("rst_d_rdata", bus.d_rdata, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Single data read with a one-cycle ack.
      mem_data = 32'h1234_5678;
      pulses_before = i_pulses;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
      wait_ready(1'b1, 10, "drd", cyc);
      checkOutput("drd_latency", 32'(cyc), 32'd2);
      checkOutput("drd_rdata", bus.d_rdata, 32'h1234_5678);
      checkOutput("drd_addr", bus.mem_addr, 32'h100);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();
      checkOutput("drd_single_pulse", 32'(bus.d_ready), 32'd0);
      checkOutput("drd_req_low", 32'(bus.mem_req), 32'd0);
      checkOutput("drd_no_i_ready", 32'(i_pulses), 32'(pulses_before));

      // Both requesters held: data four times, then the refill.
      grant_log.delete();
      mem_data = 32'hA5A5_0001;
      applyStimulus(1'b1, I_ADDR, 1'b1, 1'b0, D_ADDR, '0);
      wait_grants(10, 80, "streak");
      wait_ready(1'b0, 6, "streak", cyc);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 10; k++) begin
         exp_addr = (k == 4 || k == 9) ? I_ADDR : D_ADDR;
         checkOutput($sformatf("streak_grant%0d", k), log_at(k), exp_addr);
      end
      tick();
      tick();

      // Data write with a slow ack; client fields change after grant.
      mem_data  = 32'hDEAD_BEEF;
      ack_delay = 2;
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hCAFE_BABE);
      tick();
      checkOutput("wr_mem_req", 32'(bus.mem_req), 32'd1);
      checkOutput("wr_mem_we", 32'(bus.mem_we), 32'd1);
      checkOutput("wr_addr", bus.mem_addr, 32'h40);
      checkOutput("wr_wdata", bus.mem_wdata, 32'hCAFE_BABE);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0, 32'h0);
      tick();
      checkOutput("wr_wdata_held", bus.mem_wdata, 32'hCAFE_BABE);
      checkOutput("wr_addr_held", bus.mem_addr, 32'h40);
      tick();
      checkOutput("wr_we_at_ack", 32'(bus.mem_we), 32'd1);
      checkOutput("wr_wdata_at_ack", bus.mem_wdata, 32'hCAFE_BABE);
      wait_ready(1'b1, 5, "wr", cyc);
      checkOutput("wr_ready_after_ack", 32'(cyc), 32'd1);
      checkOutput("wr_rdata", bus.d_rdata, 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      ack_delay = 0;
      tick();

      // No ack at all: abort after TIMEOUT busy cycles.
      ack_en   = 1'b0;
      mem_data = 32'h5555_AAAA;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h80, '0);
      tick();
      checkOutput("to_err_early", 32'(bus.err), 32'd0);
      busy_cycles = bus.mem_req ? 1 : 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (bus.d_ready) break;
         if (bus.mem_req) busy_cycles++;
      end
      checkOutput("to_busy_cycles", 32'(busy_cycles), 32'(TIMEOUT));
      checkOutput("to_ready", 32'(bus.d_ready), 32'd1);
      checkOutput("to_err", 32'(bus.err), 32'd1);
      checkOutput("to_rdata", bus.d_rdata, 32'd0);
      checkOutput("to_req_low", 32'(bus.mem_req), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      ack_en = 1'b1;
      tick();
      mem_data = 32'h0BAD_F00D;
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0);
      wait_ready(1'b0, 6, "after_to", cyc);
      checkOutput("after_to_rdata", bus.i_rdata, 32'h0BAD_F00D);
      checkOutput("err_sticky", 32'(bus.err), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();

      // Reset in the middle of an instruction refill.
      ack_en = 1'b0;
      applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0, '0, '0);
      tick();
      checkOutput("rbi_busy", 32'(bus.mem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rbi_req_drop", 32'(bus.mem_req), 32'd0);
      pulses_before = i_pulses;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      checkOutput("rbi_err_clr", 32'(bus.err), 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("rbi_no_ready", 32'(i_pulses), 32'(pulses_before));
      ack_en   = 1'b1;
      mem_data = 32'h0000_0077;
      applyStimulus(1'b1, 32'h1234, 1'b0, 1'b0, '0, '0);
      wait_ready(1'b0, 6, "rbi_next", cyc);
      checkOutput("rbi_next_latency", 32'(cyc), 32'd2);
      checkOutput("rbi_next_rdata", bus.i_rdata, 32'h0000_0077);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      tick();

      // Build a streak of three, reset, and the streak must start over.
      base = grant_log.size();
      applyStimulus(1'b1, I_ADDR, 1'b1, 1'b0, D_ADDR, '0);
      wait_grants(base + 3, 30, "srst_pre");
      reset = 1'b1;
      tick();
      tick();
      base = grant_log.size();
      reset = 1'b0;
      wait_grants(base + 5, 40, "srst");
      wait_ready(1'b0, 6, "srst", cyc);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 5; k++) begin
         exp_addr = (k == 4) ? I_ADDR : D_ADDR;
         checkOutput($sformatf("srst_grant%0d", k), log_at(base + k), exp_addr);
      end
      tick();

      // Requester drops its request during the ready cycle.
      mem_data = 32'h0000_0066;
      applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0);
      wait_ready(1'b0, 6, "drop", cyc);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("drop_rdata", bus.i_rdata, 32'h0000_0066);
      base = grant_log.size();
      for (int n = 0; n < 3; n++) begin
         tick();
         checkOutput($sformatf("drop_req_low%0d", n), 32'(bus.mem_req), 32'd0);
      end
      checkOutput("drop_no_regrant", 32'(grant_log.size()), 32'(base));
      checkOutput("drop_i_ready_low", 32'(bus.i_ready), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
